// File: rtl/mem_scan_display_pkg.sv
// Shared types and constants for the memory scan display.
// Includes the state enum, default bus widths and seven-segment codes.
// The codes are active-high, with bit order gfedcba.
package mem_scan_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/mem_scan_display_if.sv
// RAM port bundle for the scan display.
// Protocol: the master presents a registered read address. The slave returns
// mem_q one cycle after it captures that address. There is no valid/ready
// handshake, so the master accounts for the fixed one-cycle latency itself.
interface mem_scan_display_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport master (output mem_addr, output mem_we, input mem_q);
  modport slave  (input mem_addr, input mem_we, output mem_q);
endinterface

// File: rtl/bcd_to_sev_seg.sv
// Hex-nibble to seven-segment decoder.
// Outputs are active-high, with bit order gfedcba.
module bcd_to_sev_seg
  import mem_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  // Map the nibble to its segment pattern.
  always_comb begin
    o_seg = SEG_0;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/mem_scan_display_timer.sv
// Hold timer that counts HOLD cycles while enabled.
// When clr is high, the timer clears to zero.
// expired is high while the count sits at HOLD_CYCLES-1.
module scan_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == LAST);

  // Count up while enabled, and saturate at the terminal value.
  always_ff @(posedge clk) begin
    if (!rst || clr) r_cnt <= '0;
    else if (en && !expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_scan_display.sv
// Walks the RAM address window START_ADDR..END_ADDR, wrapping at 2^ADDR_W.
// Each word is held on four seven-segment digits for HOLD_CYCLES cycles.
// Optional feature macro: SCAN_CHECKSUM_EN. When it is defined, the done
// display shows the mod-2^16 sum of the scanned words.
module mem_scan_display
  import mem_scan_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR  = 10'd0,
  parameter logic [ADDR_W-1:0] END_ADDR    = 10'd513,
  parameter int                HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  mem_scan_display_if.master mem,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg0,
  output logic [6:0]        seg1,
  output logic [6:0]        seg2,
  output logic [6:0]        seg3,
  output state_t            dbg_state
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DATA_W-1:0] r_disp;
  logic              w_expired;
  logic              w_tmr_clr;
  logic              w_tmr_en;
`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
`endif

  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_we   = 1'b0;
  assign cur_addr     = r_cur_addr;
  assign busy         = (r_state == ISSUE) || (r_state == WAIT) || (r_state == HOLD);
  assign done         = (r_state == DONE);
  assign dbg_state    = r_state;

  // Pause freezes the timer, so each paused HOLD cycle lengthens the word by one cycle.
  assign w_tmr_clr = (r_state == WAIT);
  assign w_tmr_en  = (r_state == HOLD) && !pause;

  scan_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_expired)
  );

  // Scan sequencer: issue address, wait one cycle for the RAM, then latch and hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_mem_addr <= START_ADDR;
      r_cur_addr <= START_ADDR;
      r_disp     <= '0;
`ifdef SCAN_CHECKSUM_EN
      r_acc      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_addr <= START_ADDR;
          r_disp     <= '0;
          if (start) begin
            r_state <= ISSUE;
`ifdef SCAN_CHECKSUM_EN
            r_acc   <= '0;
`endif
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          r_disp     <= mem.mem_q;
          r_cur_addr <= r_mem_addr;
`ifdef SCAN_CHECKSUM_EN
          r_acc      <= r_acc + mem.mem_q;
`endif
          r_state    <= HOLD;
        end
        HOLD: begin
          if (!pause && w_expired) begin
            if (r_cur_addr == END_ADDR) begin
              r_state <= DONE;
`ifdef SCAN_CHECKSUM_EN
              r_disp  <= r_acc;
`endif
            end else begin
              r_mem_addr <= r_cur_addr + 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_mem_addr <= START_ADDR;
            r_state    <= ISSUE;
`ifdef SCAN_CHECKSUM_EN
            r_acc      <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bcd_to_sev_seg u_dig0 (.i_hex(r_disp[3:0]),   .o_seg(seg0));
  bcd_to_sev_seg u_dig1 (.i_hex(r_disp[7:4]),   .o_seg(seg1));
  bcd_to_sev_seg u_dig2 (.i_hex(r_disp[11:8]),  .o_seg(seg2));
  bcd_to_sev_seg u_dig3 (.i_hex(r_disp[15:12]), .o_seg(seg3));
endmodule

// File: tb/tb_mem_scan_display.sv
// Directed bench for mem_scan_display. It uses three instances:
// A scans 510..513, B wraps through 1022..1, and C scans the single word at 5.
module tb_mem_scan_display;
  import mem_scan_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic pause_a = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] ram [1024];

  mem_scan_display_if #(.ADDR_W(10), .DATA_W(16)) if_a ();
  mem_scan_display_if #(.ADDR_W(10), .DATA_W(16)) if_b ();
  mem_scan_display_if #(.ADDR_W(10), .DATA_W(16)) if_c ();

  // RAM model: one-cycle registered read per port
  always @(posedge clk) if_a.mem_q <= ram[if_a.mem_addr];
  always @(posedge clk) if_b.mem_q <= ram[if_b.mem_addr];
  always @(posedge clk) if_c.mem_q <= ram[if_c.mem_addr];

  logic [9:0] a_cur, b_cur, c_cur;
  logic a_busy, a_done, b_busy, b_done, c_busy, c_done;
  logic [6:0] a_s0, a_s1, a_s2, a_s3, b_s0, b_s1, b_s2, b_s3, c_s0, c_s1, c_s2, c_s3;
  state_t a_st, b_st, c_st;

  mem_scan_display #(.START_ADDR(10'd510), .END_ADDR(10'd513), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .mem(if_a),
    .cur_addr(a_cur), .busy(a_busy), .done(a_done),
    .seg0(a_s0), .seg1(a_s1), .seg2(a_s2), .seg3(a_s3), .dbg_state(a_st));

  mem_scan_display #(.START_ADDR(10'd1022), .END_ADDR(10'd1), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(1'b0), .mem(if_b),
    .cur_addr(b_cur), .busy(b_busy), .done(b_done),
    .seg0(b_s0), .seg1(b_s1), .seg2(b_s2), .seg3(b_s3), .dbg_state(b_st));

  mem_scan_display #(.START_ADDR(10'd5), .END_ADDR(10'd5), .HOLD_CYCLES(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .pause(1'b0), .mem(if_c),
    .cur_addr(c_cur), .busy(c_busy), .done(c_done),
    .seg0(c_s0), .seg1(c_s1), .seg2(c_s2), .seg3(c_s3), .dbg_state(c_st));

`ifdef SCAN_CHECKSUM_EN
  localparam logic [15:0] A_DONE_EXP = 16'hD12A;
  localparam logic [15:0] B_DONE_EXP = 16'h0018;
`else
  localparam logic [15:0] A_DONE_EXP = 16'h1234;
  localparam logic [15:0] B_DONE_EXP = 16'h0002;
`endif

  // Hand-written segment table (gfedcba, active-high)
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [27:0] segs_of(input logic [15:0] v);
    return {seg7(v[15:12]), seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
  endfunction

  // driver: advance n clock edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 7);
    ram[510] = 16'h0003; ram[511] = 16'h0004; ram[512] = 16'hBEEF; ram[513] = 16'h1234;
    ram[1022] = 16'h000A; ram[1023] = 16'h000B; ram[0] = 16'h0001; ram[1] = 16'h0002;
    ram[5] = 16'h5A5A;

    // reset held for 2 cycles
    step(2);
    check("rst_state", 32'(a_st), 32'(IDLE));
    check("rst_mem_addr", 32'(if_a.mem_addr), 32'd510);
    check("rst_cur_addr", 32'(a_cur), 32'd510);
    check("rst_busy_done", {30'd0, a_busy, a_done}, 32'd0);
    check("rst_we", 32'(if_a.mem_we), 32'd0);
    check("rst_segs", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0000)));
    rst = 1'b1;
    step(10);
    check("idle_hold_state", 32'(a_st), 32'(IDLE));
    check("idle_hold_busy", 32'(a_busy), 32'd0);

    // basic scan
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("issue_state", 32'(a_st), 32'(ISSUE));
    check("issue_busy", 32'(a_busy), 32'd1);
    step(2);
    check("disp_510", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0003)));
    check("cur_510", 32'(a_cur), 32'd510);
    step(5);
    check("disp_510_still", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0003)));
    step(1);
    check("disp_511", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0004)));
    check("cur_511", 32'(a_cur), 32'd511);
    step(6);
    check("disp_512", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'hBEEF)));
    step(6);
    check("disp_513", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h1234)));
    check("cur_513", 32'(a_cur), 32'd513);
    step(3);
    check("hold_last_busy", {30'd0, a_busy, a_done}, 32'd2);
    step(1);
    check("done_flags", {30'd0, a_busy, a_done}, 32'd1);
    check("done_disp", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(A_DONE_EXP)));

    // rescan from DONE, with pause and an ignored start during HOLD
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("restart_state", 32'(a_st), 32'(ISSUE));
    check("restart_addr", 32'(if_a.mem_addr), 32'd510);
    step(2);
    check("re_disp_510", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0003)));
    step(1);
    pause_a = 1'b1;
    start_a = 1'b1;
    step(3);
    pause_a = 1'b0;
    start_a = 1'b0;
    check("pause_state", 32'(a_st), 32'(HOLD));
    step(4);
    check("pause_extended", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0003)));
    check("pause_wait_state", 32'(a_st), 32'(WAIT));
    step(1);
    check("pause_next_disp", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0004)));
    check("pause_next_cur", 32'(a_cur), 32'd511);

    // reset during HOLD of 511
    step(1);
    rst = 1'b0;
    step(1);
    check("midrst_state", 32'(a_st), 32'(IDLE));
    check("midrst_disp", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0000)));
    check("midrst_addr", 32'(if_a.mem_addr), 32'd510);
    check("midrst_cur", 32'(a_cur), 32'd510);
    rst = 1'b1;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(2);
    check("rescan_disp", 32'({a_s3, a_s2, a_s1, a_s0}), 32'(segs_of(16'h0003)));
    check("rescan_cur", 32'(a_cur), 32'd510);

    // wrap scan 1022,1023,0,1
    check("b_idle", 32'(b_st), 32'(IDLE));
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    step(2);
    check("wrap_cur_1022", 32'(b_cur), 32'd1022);
    check("wrap_disp_1022", 32'({b_s3, b_s2, b_s1, b_s0}), 32'(segs_of(16'h000A)));
    step(6);
    check("wrap_cur_1023", 32'(b_cur), 32'd1023);
    step(6);
    check("wrap_cur_0", 32'(b_cur), 32'd0);
    check("wrap_disp_0", 32'({b_s3, b_s2, b_s1, b_s0}), 32'(segs_of(16'h0001)));
    step(6);
    check("wrap_cur_1", 32'(b_cur), 32'd1);
    step(4);
    check("wrap_done", {30'd0, b_busy, b_done}, 32'd1);
    check("wrap_done_disp", 32'({b_s3, b_s2, b_s1, b_s0}), 32'(segs_of(B_DONE_EXP)));

    // single-word window
    start_c = 1'b1;
    step(1);
    start_c = 1'b0;
    step(2);
    check("single_disp", 32'({c_s3, c_s2, c_s1, c_s0}), 32'(segs_of(16'h5A5A)));
    check("single_not_done", 32'(c_done), 32'd0);
    step(3);
    check("single_done", {30'd0, c_busy, c_done}, 32'd1);
    check("single_done_disp", 32'({c_s3, c_s2, c_s1, c_s0}), 32'(segs_of(16'h5A5A)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
